// File: rtl/move_btn_conditioner.sv
// Move-button conditioner: synchronises, debounces and optionally auto-repeats the
// raw move pad, producing one registered single-cycle pulse per accepted press/repeat.
module move_btn_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter bit REPEAT_EN       = 1'b1,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int CNT_W           = 24
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    input  logic hold_off,
    output logic move_pulse,
    output logic btn_level,
    output logic repeat_active
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESS_WAIT,
        ST_HELD,
        ST_REPEAT,
        ST_RELEASE_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   move_pulse_q, move_pulse_d;
    logic                   btn_level_q, btn_level_d;
    logic                   repeat_active_q, repeat_active_d;
    logic                   btn_s;
    logic                   pulse_issue;

    assign btn_s = sync_q[SYNC_STAGES-1];

    // NOTE: every signal assigned here gets a default first, so no latch can be inferred.
    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], btn_raw};
        state_d     = state_q;
        cnt_d       = cnt_q;
        btn_level_d = btn_level_q;
        pulse_issue = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (btn_s) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!btn_s) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == DEB_LAST) begin
                    state_d     = ST_HELD;
                    cnt_d       = '0;
                    btn_level_d = 1'b1;
                    pulse_issue = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HELD: begin
                if (!btn_s) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = '0;
                end else if (REPEAT_EN && cnt_q == DELAY_LAST) begin
                    state_d     = ST_REPEAT;
                    cnt_d       = '0;
                    pulse_issue = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    // Saturates only when repeat is disabled and the button is held forever.
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_REPEAT: begin
                if (!btn_s) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = '0;
                end else if (cnt_q == PERIOD_LAST) begin
                    cnt_d       = '0;
                    pulse_issue = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_RELEASE_WAIT: begin
                if (btn_s) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d     = ST_IDLE;
                    btn_level_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        move_pulse_d    = pulse_issue & ~hold_off;
        repeat_active_d = (state_d == ST_REPEAT);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q          <= '0;
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            move_pulse_q    <= 1'b0;
            btn_level_q     <= 1'b0;
            repeat_active_q <= 1'b0;
        end else begin
            sync_q          <= sync_d;
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            move_pulse_q    <= move_pulse_d;
            btn_level_q     <= btn_level_d;
            repeat_active_q <= repeat_active_d;
        end
    end

    assign move_pulse    = move_pulse_q;
    assign btn_level     = btn_level_q;
    assign repeat_active = repeat_active_q;

endmodule
